// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: opcode/funct constants, ALU encodings and the instruction
// decode helper shared by the decode stage.
package id_pipe_pkg;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SYNC = 6'b001111;

    localparam logic [7:0] ALU_NOP = 8'b00000000;
    localparam logic [7:0] ALU_AND = 8'b00100100;
    localparam logic [7:0] ALU_OR  = 8'b00100101;
    localparam logic [7:0] ALU_XOR = 8'b00100110;
    localparam logic [7:0] ALU_NOR = 8'b00100111;
    localparam logic [7:0] ALU_SLL = 8'b01111100;
    localparam logic [7:0] ALU_SRL = 8'b00000010;
    localparam logic [7:0] ALU_SRA = 8'b00000011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    typedef struct packed {
        logic        invalid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        re1;
        logic        re2;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] imm;
    } dec_t;

    function automatic logic [7:0] fn_aluop(input logic [5:0] fn);
        logic [7:0] a;
        case (fn)
            F_AND:          a = ALU_AND;
            F_OR:           a = ALU_OR;
            F_XOR:          a = ALU_XOR;
            F_NOR:          a = ALU_NOR;
            F_SLLV, F_SLL:  a = ALU_SLL;
            F_SRLV, F_SRL:  a = ALU_SRL;
            F_SRAV, F_SRA:  a = ALU_SRA;
            default:        a = ALU_NOP;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] op_aluop(input logic [5:0] op);
        logic [7:0] a;
        case (op)
            OP_ANDI:         a = ALU_AND;
            OP_ORI, OP_LUI:  a = ALU_OR;
            OP_XORI:         a = ALU_XOR;
            default:         a = ALU_NOP;
        endcase
        return a;
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic       r_grp;
        logic       s_grp;
        logic       y_grp;
        logic       i_grp;
        op = inst[31:26];
        fn = inst[5:0];
        r_grp = op == OP_SPECIAL && inst[10:6] == 5'd0 &&
                fn inside {F_AND, F_OR, F_XOR, F_NOR, F_SLLV, F_SRLV, F_SRAV};
        s_grp = op == OP_SPECIAL && inst[25:21] == 5'd0 &&
                fn inside {F_SLL, F_SRL, F_SRA};
        y_grp = op == OP_SPECIAL && inst[10:6] == 5'd0 && fn == F_SYNC;
        i_grp = op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
        d.invalid = 1'b1;
        d.aluop   = ALU_NOP;
        d.alusel  = SEL_NOP;
        d.re1     = Disable;
        d.re2     = Disable;
        d.wreg    = Disable;
        d.wd      = NOP_REG_ADDR;
        d.imm     = '0;
        unique case (1'b1)
            r_grp: begin
                d.invalid = 1'b0;
                d.aluop   = fn_aluop(fn);
                d.alusel  = fn[5] ? SEL_LOGIC : SEL_SHIFT;
                d.re1     = Enable;
                d.re2     = Enable;
                d.wreg    = Enable;
                d.wd      = inst[15:11];
            end
            s_grp: begin
                d.invalid = 1'b0;
                d.aluop   = fn_aluop(fn);
                d.alusel  = SEL_SHIFT;
                d.re2     = Enable;
                d.wreg    = Enable;
                d.wd      = inst[15:11];
                d.imm     = {27'd0, inst[10:6]};
            end
            i_grp: begin
                d.invalid = 1'b0;
                d.aluop   = op_aluop(op);
                d.alusel  = SEL_LOGIC;
                d.re1     = Enable;
                d.wreg    = Enable;
                d.wd      = inst[20:16];
                d.imm     = (op == OP_LUI) ? {inst[15:0], 16'h0000}
                                           : {16'h0000, inst[15:0]};
            end
            y_grp || op == OP_PREF: begin
                d.invalid = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: one operand's select between immediate, regfile and
// N prioritised forwarding sources (source 0 wins).
import id_pipe_pkg::*;

module id_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int N_FWD  = 2
) (
    input  logic                      re,
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         imm,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [N_FWD-1:0]          fwd_wreg,
    input  logic [N_FWD*REG_AW-1:0]   fwd_wd,
    input  logic [N_FWD*DATA_W-1:0]   fwd_wdata,
    output logic [DATA_W-1:0]         data
);

    always_comb begin
        data = rf_data;
        // Walk oldest to youngest so the lowest index is applied last.
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && fwd_wd[k*REG_AW +: REG_AW] == addr) begin
                data = fwd_wdata[k*DATA_W +: DATA_W];
            end
        end
        if (addr == '0) begin
            data = '0;
        end
        if (re == Disable) begin
            data = imm;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// id_pipe: registered MIPS decode stage with forwarding, load-use stall and
// ID/EX valid/ready register. Define ID_PERF_CNT_EN for the stall counter.
import id_pipe_pkg::*;

module id_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int N_FWD    = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]              stall_cnt_o,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        pc_i,
    input  logic [31:0]              inst_i,
    output logic [REG_AW-1:0]        reg1_addr_o,
    output logic [REG_AW-1:0]        reg2_addr_o,
    output logic                     reg1_read_o,
    output logic                     reg2_read_o,
    input  logic [DATA_W-1:0]        reg1_data_i,
    input  logic [DATA_W-1:0]        reg2_data_i,
    input  logic [N_FWD-1:0]         fwd_wreg_i,
    input  logic [N_FWD*REG_AW-1:0]  fwd_wd_i,
    input  logic [N_FWD*DATA_W-1:0]  fwd_wdata_i,
    input  logic                     ex_load_i,
    input  logic                     flush_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALUOP_W-1:0]       aluop_o,
    output logic [ALUSEL_W-1:0]      alusel_o,
    output logic [DATA_W-1:0]        reg1_o,
    output logic [DATA_W-1:0]        reg2_o,
    output logic [REG_AW-1:0]        wd_o,
    output logic                     wreg_o,
    output logic [DATA_W-1:0]        pc_o,
    output logic                     inst_invalid_o
);

    dec_t               dec;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [REG_AW-1:0]  ex_wd;
    logic               stall;
    logic               capture;

    assign dec         = decode(inst_i);
    assign imm         = DATA_W'(dec.imm);
    assign reg1_addr_o = REG_AW'(inst_i[25:21]);
    assign reg2_addr_o = REG_AW'(inst_i[20:16]);
    assign reg1_read_o = dec.re1;
    assign reg2_read_o = dec.re2;

    id_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .N_FWD  (N_FWD)
    ) u_fwd1 (
        .re        (dec.re1),
        .addr      (reg1_addr_o),
        .imm       (imm),
        .rf_data   (reg1_data_i),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .data      (op1)
    );

    id_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .N_FWD  (N_FWD)
    ) u_fwd2 (
        .re        (dec.re2),
        .addr      (reg2_addr_o),
        .imm       (imm),
        .rf_data   (reg2_data_i),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .data      (op2)
    );

    // A load in EX cannot forward yet, so a dependent reader must wait.
    assign ex_wd = fwd_wd_i[REG_AW-1:0];
    assign stall = in_valid && ex_load_i && fwd_wreg_i[0] &&
                   ex_wd != '0 &&
                   ((dec.re1 && ex_wd == reg1_addr_o) ||
                    (dec.re2 && ex_wd == reg2_addr_o));

    assign in_ready = !rst && !flush_i && !stall &&
                      (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            aluop_o        <= ALUOP_W'(ALU_NOP);
            alusel_o       <= ALUSEL_W'(SEL_NOP);
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= REG_AW'(NOP_REG_ADDR);
            wreg_o         <= Disable;
            pc_o           <= '0;
            inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            aluop_o        <= ALUOP_W'(dec.aluop);
            alusel_o       <= ALUSEL_W'(dec.alusel);
            reg1_o         <= op1;
            reg2_o         <= op2;
            wd_o           <= REG_AW'(dec.wd);
            wreg_o         <= dec.wreg;
            pc_o           <= pc_i;
            inst_invalid_o <= dec.invalid;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall && stall_cnt_o != 32'hFFFF_FFFF) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed and random checks of id_pipe against a
// behavioural model of the decode/forward/stall/handshake rules.
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic        r1e;
    logic        r2e;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [1:0]  fwreg;
    logic [9:0]  fwd;
    logic [63:0] fwdata;
    logic        ex_load;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pco;
    logic        inv;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] exp_cnt;
`endif

    logic [31:0] rf [32];
    logic [5:0]  rfn [8] = '{6'h24, 6'h25, 6'h26, 6'h27,
                             6'h04, 6'h06, 6'h07, 6'h0f};
    logic [5:0]  sfn [3] = '{6'h00, 6'h02, 6'h03};
    logic [5:0]  iop [5] = '{6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h33};

    int          vec = 0;
    int          bad = 0;
    logic        rdy_seen;

    typedef struct packed {
        logic        v;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic        w;
        logic [31:0] pc;
        logic        inv;
    } out_t;

    typedef struct packed {
        logic        ok;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic        r1;
        logic        r2;
        logic        w;
        logic [4:0]  wd;
        logic [31:0] imm;
    } rdec_t;

    out_t ex;
    out_t snap;

    always #5 clk = ~clk;

    assign r1d = rf[r1a];
    assign r2d = rf[r2a];

    id_pipe dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ID_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pc_i           (pc),
        .inst_i         (inst),
        .reg1_addr_o    (r1a),
        .reg2_addr_o    (r2a),
        .reg1_read_o    (r1e),
        .reg2_read_o    (r2e),
        .reg1_data_i    (r1d),
        .reg2_data_i    (r2d),
        .fwd_wreg_i     (fwreg),
        .fwd_wd_i       (fwd),
        .fwd_wdata_i    (fwdata),
        .ex_load_i      (ex_load),
        .flush_i        (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .aluop_o        (aluop),
        .alusel_o       (alusel),
        .reg1_o         (reg1),
        .reg2_o         (reg2),
        .wd_o           (wd),
        .wreg_o         (wreg),
        .pc_o           (pco),
        .inst_invalid_o (inv)
    );

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        vec++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [127:0] dut_out();
        out_t o;
        o = {out_valid, aluop, alusel, reg1, reg2, wd, wreg, pco, inv};
        return 128'(o);
    endfunction

    // Instruction meaning straight from the ISA table.
    function automatic rdec_t ref_dec(input logic [31:0] i);
        rdec_t      d;
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        d  = '0;
        if (op == 6'h00 && i[10:6] == 5'd0 && fn == 6'h0f) begin
            d.ok = 1'b1;
        end else if (op == 6'h00 && i[10:6] == 5'd0 &&
                     fn inside {6'h24, 6'h25, 6'h26, 6'h27,
                                6'h04, 6'h06, 6'h07}) begin
            d.ok = 1'b1; d.r1 = 1'b1; d.r2 = 1'b1;
            d.w = 1'b1; d.wd = i[15:11];
            case (fn)
                6'h24: begin d.op = 8'h24; d.sel = 3'd1; end
                6'h25: begin d.op = 8'h25; d.sel = 3'd1; end
                6'h26: begin d.op = 8'h26; d.sel = 3'd1; end
                6'h27: begin d.op = 8'h27; d.sel = 3'd1; end
                6'h04: begin d.op = 8'h7c; d.sel = 3'd2; end
                6'h06: begin d.op = 8'h02; d.sel = 3'd2; end
                default: begin d.op = 8'h03; d.sel = 3'd2; end
            endcase
        end else if (op == 6'h00 && i[25:21] == 5'd0 &&
                     fn inside {6'h00, 6'h02, 6'h03}) begin
            d.ok = 1'b1; d.r2 = 1'b1; d.w = 1'b1;
            d.wd = i[15:11]; d.sel = 3'd2;
            d.imm = 32'(i[10:6]);
            d.op = (fn == 6'h00) ? 8'h7c : (fn == 6'h02) ? 8'h02 : 8'h03;
        end else if (op inside {6'h0c, 6'h0d, 6'h0e, 6'h0f}) begin
            d.ok = 1'b1; d.r1 = 1'b1; d.w = 1'b1;
            d.wd = i[20:16]; d.sel = 3'd1;
            d.imm = (op == 6'h0f) ? 32'(i[15:0]) << 16 : 32'(i[15:0]);
            d.op = (op == 6'h0c) ? 8'h24 : (op == 6'h0e) ? 8'h26 : 8'h25;
        end else if (op == 6'h33) begin
            d.ok = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [31:0] ref_opnd(input logic re,
                                             input logic [4:0] a,
                                             input logic [31:0] imm);
        if (!re) return imm;
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < 2; k++) begin
            if (fwreg[k] && fwd[k*5 +: 5] == a) return fwdata[k*32 +: 32];
        end
        return rf[a];
    endfunction

    task automatic cyc();
        rdec_t      d;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] w0;
        logic       st;
        logic       rdy;
        out_t       nx;
        @(negedge clk);
        d  = ref_dec(inst);
        rs = inst[25:21];
        rt = inst[20:16];
        w0 = fwd[4:0];
        st = in_valid && ex_load && fwreg[0] && w0 != 5'd0 &&
             ((d.r1 && w0 == rs) || (d.r2 && w0 == rt));
        rdy = !rst && !flush && !st && (!ex.v || out_ready);
        rdy_seen = in_ready;
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("rd_en", 128'({r1e, r2e}), 128'({d.r1, d.r2}));
        chk("rd_addr", 128'({r1a, r2a}), 128'({rs, rt}));
        nx = ex;
        if (rst) begin
            nx = '0;
        end else if (flush) begin
            nx.v = 1'b0;
        end else if (in_valid && rdy) begin
            nx.v   = 1'b1;
            nx.op  = d.op;
            nx.sel = d.sel;
            nx.a   = ref_opnd(d.r1, rs, d.imm);
            nx.b   = ref_opnd(d.r2, rt, d.imm);
            nx.wd  = d.wd;
            nx.w   = d.w;
            nx.pc  = pc;
            nx.inv = !d.ok;
        end else if (out_ready) begin
            nx.v = 1'b0;
        end
`ifdef ID_PERF_CNT_EN
        if (rst) exp_cnt = 32'd0;
        else if (st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
        @(posedge clk);
        #1;
        ex = nx;
        chk("id_ex", dut_out(), 128'(ex));
`ifdef ID_PERF_CNT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(exp_cnt));
`endif
    endtask

    function automatic logic [31:0] gen();
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] sa;
        rs = 5'($urandom_range(7));
        rt = 5'($urandom_range(7));
        rd = 5'($urandom_range(7));
        sa = 5'($urandom_range(31));
        case ($urandom_range(5))
            0, 1: return {6'h00, rs, rt, rd, 5'd0, rfn[$urandom_range(7)]};
            2: return {6'h00, 5'd0, rt, rd, sa, sfn[$urandom_range(2)]};
            3: return {iop[$urandom_range(4)], rs, rt, 16'($urandom)};
            4: return {6'h00, rs, rt, rd, sa, 6'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h0000_0F0F;
        ex = '0;
`ifdef ID_PERF_CNT_EN
        exp_cnt = 32'd0;
`endif
        rst = 1'b1; in_valid = 1'b0; pc = 32'd0; inst = 32'd0;
        fwreg = 2'b00; fwd = '0; fwdata = '0;
        ex_load = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready", 128'(rdy_seen), 128'(0));
        chk("rst_state", dut_out(), 128'(0));

        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; pc = 32'h100;
        inst = {6'h0d, 5'd0, 5'd1, 16'h1234};
        cyc();
        chk("ori_valid", 128'(out_valid), 128'(1));
        chk("ori_aluop", 128'(aluop), 128'(8'h25));
        chk("ori_ops", 128'({reg1, reg2}), 128'({32'd0, 32'h1234}));
        chk("ori_dest", 128'({wd, wreg}), 128'({5'd1, 1'b1}));

        inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
        fwreg = 2'b11; fwd = {5'd1, 5'd1};
        fwdata = {32'h5555, 32'hAAAA};
        cyc();
        chk("fwd_prio", 128'(reg1), 128'(32'hAAAA));
        inst = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h25};
        fwd = {5'd0, 5'd0};
        cyc();
        chk("fwd_r0", 128'(reg1), 128'(0));

        inst = {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h25};
        fwreg = 2'b01; fwd = {5'd9, 5'd2}; ex_load = 1'b1;
        cyc();
        chk("lu_stall", 128'(rdy_seen), 128'(0));
        chk("lu_bubble", 128'(out_valid), 128'(0));
        fwreg = 2'b10; fwd = {5'd2, 5'd9}; ex_load = 1'b0;
        fwdata = {32'h77, 32'h0};
        cyc();
        chk("lu_capture", 128'({out_valid, reg1}), 128'({1'b1, 32'h77}));
`ifdef ID_PERF_CNT_EN
        chk("lu_cnt", 128'(stall_cnt), 128'(1));
`endif

        fwreg = 2'b00;
        inst = {6'h0e, 5'd7, 5'd6, 16'hF0F0};
        cyc();
        snap = out_t'(dut_out());
        out_ready = 1'b0;
        inst = {11'd0, 5'd5, 5'd4, 5'd3, 6'h00};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold", dut_out(), 128'(snap));
            chk("bp_ready", 128'(rdy_seen), 128'(0));
        end
        out_ready = 1'b1;
        cyc();
        chk("sll_ops", 128'({reg1, reg2}), 128'({32'd3, 32'h0F0F}));
        chk("sll_aluop", 128'(aluop), 128'(8'h7c));
        inst = {6'h3f, 26'h155_5555};
        cyc();
        chk("bad_op", 128'({inv, wreg}), 128'({1'b1, 1'b0}));

        flush = 1'b1;
        inst = {6'h0d, 5'd0, 5'd1, 16'h0001};
        cyc();
        chk("flush", 128'({out_valid, rdy_seen}), 128'(0));
        flush = 1'b0;
        cyc();
        out_ready = 1'b0;
        inst = {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h25};
        fwreg = 2'b01; fwd = {5'd0, 5'd2}; ex_load = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid", dut_out(), 128'(0));
        rst = 1'b0; ex_load = 1'b0; out_ready = 1'b1;

        for (int n = 0; n < 400; n++) begin
            in_valid  = $urandom_range(3) != 0;
            out_ready = $urandom_range(3) != 0;
            flush     = $urandom_range(31) == 0;
            rst       = $urandom_range(63) == 0;
            ex_load   = $urandom_range(2) == 0;
            fwreg     = 2'($urandom);
            fwd       = {5'($urandom_range(7)), 5'($urandom_range(7))};
            fwdata    = {$urandom, $urandom};
            pc        = $urandom;
            inst      = gen();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, parametrised instruction-decode stage for the openMips pipeline. Decodes one 32-bit MIPS instruction per accepted handshake, reads the register file, resolves operands through N prioritised forwarding ports, detects load-use hazards and stalls, and presents the result in an ID/EX output register with valid/ready flow control. Sits between the IF/ID register and the EX stage and supersedes the purely combinational decoder.

## Interface
- DATA_W, 32, data/operand width
- REG_AW, 5, register address width
- N_FWD, 2, number of forwarding sources; index 0 is youngest (EX), highest priority
- ALUOP_W, 8, aluop field width
- ALUSEL_W, 3, alusel field width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- pc_i  in  DATA_W  instruction address
- inst_i  in  32  instruction word
- reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses (rs / rt), combinational
- reg1_read_o / reg2_read_o  out  1  regfile read enables, combinational
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle
- fwd_wreg_i  in  N_FWD  per-source write enable
- fwd_wd_i  in  N_FWD*REG_AW  per-source destination, source k at [k*REG_AW +: REG_AW]
- fwd_wdata_i  in  N_FWD*DATA_W  per-source write data
- ex_load_i  in  1  source 0 is a load; its data is not yet valid
- flush_i  in  1  discard pending and output instruction
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts
- aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o  out  ALUOP_W/ALUSEL_W/DATA_W/DATA_W/REG_AW/1/DATA_W/1  registered ID/EX fields
- stall_cnt_o  out  32  load-use stall cycles (only with ID_PERF_CNT_EN)

## Operation
- Decode set: AND/OR/XOR/NOR, SLLV/SRLV/SRAV, SLL/SRL/SRA (inst[31:21]==0, imm = shamt zero-extended), SYNC, ORI/ANDI/XORI (imm zero-extended), LUI (imm<<16, OR with rs), PREF. R-type writes rd, I-type writes rt.
- Operand with read enable 0 takes imm; otherwise operand = forwarded or regfile value.
- Forwarding: lowest k with fwd_wreg_i[k] && fwd_wd_i[k]==addr && read enabled wins; address 0 never forwarded, operand for $0 is 0 regardless of regfile/forward data.
- Unknown opcode/funct: aluop/alusel NOP, wreg_o=0, inst_invalid_o=1, operands 0.
- Hazard: stall = in_valid && ex_load_i && fwd_wreg_i[0] && fwd_wd_i[0]!=0 && (matches an enabled rs or rt read).
- in_ready = !rst && !flush_i && !stall && (!out_valid || out_ready).
- Capture (in_valid && in_ready): output register loads decoded fields, out_valid=1.
- No capture && out_ready: out_valid=0 (bubble); fields hold.
- No capture && !out_ready: all outputs hold (stable while valid).
- flush_i: out_valid=0 next cycle, no capture; flush wins over capture and stall.

## Timing
- Decode, forwarding, hazard, in_ready combinational; ID/EX fields 1-cycle latency from acceptance.
- Full throughput (1 instr/cycle) with out_ready held 1 and no hazard.
- Load-use costs exactly one bubble when EX advances the load the following cycle.
- Reset: out_valid=0, aluop_o=NOP, alusel_o=NOP, reg1_o=reg2_o=pc_o=0, wd_o=0, wreg_o=0, inst_invalid_o=0, stall_cnt_o=0; in_ready=0 while rst high. Reset mid-stall or mid-backpressure discards the held instruction.

## Configuration
- ID_PERF_CNT_EN defined: stall_cnt_o increments by 1 each cycle stall is asserted, saturates at 0xFFFF_FFFF, cleared by rst only.
- Undefined: counter and stall_cnt_o port absent; no other behaviour change.

## Structure
- Shared package/defines: opcode/funct constants, aluop/alusel encodings, NOP register address, Enable/Disable.
- One sub-module: id_fwd_mux (one operand's priority forwarding select over N_FWD sources), instantiated twice.

## Test plan
- ORI $1,$0,0x1234, out_ready=1 -> next cycle out_valid=1, aluop=OR, reg1_o=0, reg2_o=0x00001234, wd_o=1, wreg_o=1.
- OR $3,$1,$2 with src0 writing $1=0xAAAA and src1 writing $1=0x5555 -> reg1_o=0xAAAA; with dest $0 forwarded -> reg1_o=0.
- ex_load_i=1, src0 dest $2, ID reads $2 -> in_ready=0 one cycle, one bubble, then capture; stall_cnt_o=1 with macro.
- out_ready=0 for 3 cycles after capture -> all outputs stable, in_ready=0; release -> next instruction captured.
- SLL $4,$5,3 -> reg1_o=3, reg2_o=$5 value, aluop=SLL; opcode 6'h3F -> inst_invalid_o=1, wreg_o=0.
- flush_i with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing captured; rst mid-stall -> all outputs at reset values.
